fetch_redirect_ctrl: RTL

- Fetch sequencer for the RISC-V core.
- Owns the PC register and issues instruction-memory requests over a req/ready handshake.
- Computes the branch target (BranchAddr + (Extended_imm << 1)) and redirects the PC on taken branches.
- Discards any in-flight wrong-path fetch; sits between the hazard/branch-resolve logic and instruction memory.

---
 rtl/riscv_fetch_pkg.sv | 19 +
 rtl/branch_target_gen.sv | 16 +
 rtl/fetch_redirect_ctrl.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared types and defaults for the instruction fetch sequencer.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    BOOT,
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT  = 4;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/branch_target_gen.sv
// Branch target adder: BranchAddr + (Extended_imm << 1), plus word-alignment check.
module branch_target_gen (
  input  logic [31:0] BranchAddr,
  input  logic [31:0] Extended_imm,
  output logic [31:0] Target,
  output logic        Misaligned
);

  logic [31:0] w_offset;

  // Immediate is in halfword units; the top bit shifts out, so the add wraps modulo 2^32.
  assign w_offset   = {Extended_imm[30:0], 1'b0};
  assign Target     = BranchAddr + w_offset;
  assign Misaligned = |Target[1:0];

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch sequencer: owns the PC, issues req/ready fetches and redirects on taken branches.
// Optional redirect/discard statistics counters are enabled by FETCH_REDIRECT_STATS_EN.
module fetch_redirect_ctrl
  import riscv_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Stall,
  input  logic        BranchValid,
  input  logic        BranchTaken,
  input  logic [31:0] BranchAddr,
  input  logic [31:0] Extended_imm,
  input  logic        ImemReady,
  input  logic [31:0] ImemData,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  output logic [31:0] Inst,
  output logic [31:0] InstPC,
  output logic        InstValid,
  output logic        Flush,
  output logic        MisalignErr
`ifdef FETCH_REDIRECT_STATS_EN
  ,
  output logic [31:0] RedirectCount,
  output logic [31:0] DiscardCount
`endif
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_pending;
  logic         r_req;
  logic [31:0]  r_inst;
  logic [31:0]  r_inst_pc;
  logic         r_inst_valid;
  logic         r_flush;
  logic         r_misalign;

  logic [31:0]  w_target;
  logic         w_misaligned;
  logic         w_taken;
  logic         w_redirect;
  logic [31:0]  w_pc_next;

  branch_target_gen u_target (
    .BranchAddr   (BranchAddr),
    .Extended_imm (Extended_imm),
    .Target       (w_target),
    .Misaligned   (w_misaligned)
  );

  assign w_taken    = BranchValid & BranchTaken;
  assign w_redirect = w_taken & ~w_misaligned;
  assign w_pc_next  = r_pc + 32'(PC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_pending    <= 32'h0;
      r_req        <= 1'b0;
      r_inst       <= 32'h0;
      r_inst_pc    <= 32'h0;
      r_inst_valid <= 1'b0;
      r_flush      <= 1'b0;
      r_misalign   <= 1'b0;
    end else begin
      r_flush      <= w_redirect;
      r_misalign   <= w_taken & w_misaligned;
      r_inst_valid <= 1'b0;
      unique case (r_state)
        BOOT: begin
          r_state <= IDLE;
          if (w_redirect) r_pc <= w_target;
        end
        IDLE: begin
          if (w_redirect) begin
            r_pc <= w_target;
          end else if (!Stall) begin
            r_state <= WAIT;
            r_req   <= 1'b1;
          end
        end
        WAIT: begin
          if (ImemReady) begin
            if (w_redirect) begin
              r_pc    <= w_target;
              r_state <= IDLE;
              r_req   <= 1'b0;
            end else begin
              r_inst       <= ImemData;
              r_inst_pc    <= r_pc;
              r_inst_valid <= 1'b1;
              r_pc         <= w_pc_next;
              // Stall only holds off the next request; this one has already completed.
              r_state      <= Stall ? IDLE : WAIT;
              r_req        <= ~Stall;
            end
          end else if (w_redirect) begin
            r_pending <= w_target;
            r_state   <= DISCARD;
          end
        end
        DISCARD: begin
          if (ImemReady) begin
            r_pc    <= w_redirect ? w_target : r_pending;
            r_state <= IDLE;
            r_req   <= 1'b0;
          end else if (w_redirect) begin
            r_pending <= w_target;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign ImemReq     = r_req;
  assign ImemAddr    = r_pc;
  assign Inst        = r_inst;
  assign InstPC      = r_inst_pc;
  assign InstValid   = r_inst_valid;
  assign Flush       = r_flush;
  assign MisalignErr = r_misalign;

`ifdef FETCH_REDIRECT_STATS_EN
  logic [31:0] r_redirect_cnt;
  logic [31:0] r_discard_cnt;
  logic        w_drop;

  assign w_drop = ImemReady & (((r_state == WAIT) & w_redirect) | (r_state == DISCARD));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_redirect_cnt <= 32'h0;
      r_discard_cnt  <= 32'h0;
    end else begin
      if (w_redirect) r_redirect_cnt <= sat_inc(r_redirect_cnt);
      if (w_drop)     r_discard_cnt  <= sat_inc(r_discard_cnt);
    end
  end

  assign RedirectCount = r_redirect_cnt;
  assign DiscardCount  = r_discard_cnt;
`endif

endmodule
